uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: none; widths fixed (16-bit divider, 8-bit data).
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 rx_i  input  1  asynchronous serial line, idle high.
REQ-005 busy_o  output  1  high whenever FSM not IDLE.
REQ-006 cfg_en_i  input  1  receiver enable; low forces IDLE.
REQ-007 cfg_div_i  input  16  bit period = cfg_div_i+1 clk cycles.
REQ-008 cfg_parity_en_i  input  1  parity bit present.
REQ-009 cfg_parity_sel_i  input  2  00 odd, 01 even, 10 space(0), 11 mark(1).
REQ-010 cfg_bits_i  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-011 rx_data_o  output  8  received byte, LSB-first assembled, unused MSBs zero.
REQ-012 rx_valid_o  output  1  rx_data_o holds an unread byte.
REQ-013 rx_ready_i  input  1  consumer accepts byte when rx_valid_o&&rx_ready_i.
REQ-014 err_parity_o, err_frame_o, err_overrun_o  output  1 each  one-cycle error pulses.

Function
REQ-015 rx_i SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-016 FSM states SHALL be IDLE, START_BIT, DATA, PARITY, STOP_BIT.
REQ-017 IDLE: synchronized rx low with cfg_en_i high -> START_BIT, baud counter cleared.
REQ-018 START_BIT: after cfg_div_i>>1 cycles sample line; high -> IDLE (glitch, no flags); low -> DATA.
REQ-019 Baud counter SHALL count 0..cfg_div_i and wrap, producing one sample tick per wrap, so each subsequent sample falls at bit centre.
REQ-020 DATA: each tick shifts sample into MSB of an 8-bit shift register and counts; after N=5..8 bits -> PARITY if cfg_parity_en_i else STOP_BIT.
REQ-021 Final byte SHALL be right-aligned: shift register >> (8-N), upper bits zero.
REQ-022 PARITY: compare sample to expected (odd: ~^data, even: ^data, space 0, mark 1); mismatch latched for frame end.
REQ-023 STOP_BIT: one sample only; low = framing error; always -> IDLE; second stop bit not checked.
REQ-024 Cycle after stop sample: rx_data_o loaded, rx_valid_o set; err_parity_o / err_frame_o pulse if applicable; byte delivered even on error.
REQ-025 rx_valid_o SHALL stay high, data stable, until handshake; cleared the cycle after rx_valid_o&&rx_ready_i.
REQ-026 Frame completes while rx_valid_o high and no handshake that cycle: old data kept, new byte dropped, err_overrun_o pulses.
REQ-027 Frame completes in same cycle as handshake: new byte loaded, rx_valid_o stays high, no overrun.
REQ-028 cfg_en_i low: FSM -> IDLE next cycle, counters cleared, rx_valid_o cleared, no error pulses.
REQ-029 Config inputs SHALL be stable while busy_o high; changes mid-frame give undefined data but SHALL not hang the FSM.

Reset
REQ-030 rst_i high on a clock edge: FSM IDLE, rx_data_o 0, rx_valid_o 0, all err_* 0, busy_o 0, counters 0, synchronizer 1; reset mid-frame abandons frame silently.

Configuration
REQ-031 UART_RX_MAJORITY_EN defined: each sample = majority of line at tick-1, tick, tick+1; cfg_div_i SHALL be >= 4.
REQ-032 UART_RX_MAJORITY_EN undefined: single sample at tick; no extra flops.

Structure
REQ-033 Package uart_pkg SHALL hold the rx FSM enum, parity-select encodings, data-bits encodings.
REQ-034 Sub-module uart_rx_baud: counter, half/full period compare, sample tick output.

Verification
REQ-035 div=15, 8N1, send 0xA5 -> rx_data_o=0xA5, rx_valid_o high, no err_*.
REQ-036 div=15, 7 bits even parity, send 0x35 with parity bit 1 (wrong) -> rx_data_o=0x35, err_parity_o one pulse.
REQ-037 div=15, 8N1, send 0x3C with stop bit low -> rx_data_o=0x3C, err_frame_o pulse, next frame 0x81 received correctly.
REQ-038 rx_ready_i held low, send 0x11 then 0x22 -> rx_data_o stays 0x11, err_overrun_o pulse on second frame.
REQ-039 rx_i low pulse of 3 cycles at div=15 -> returns IDLE, rx_valid_o never asserts, no err_*.
REQ-040 rst_i asserted mid-DATA of 0x5A, then send 0xC3 -> all outputs reset values, then rx_data_o=0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART receiver: FSM state
//                enum, parity-select and data-bits encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DIV_W  = 16;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP_BIT  = 3'd4
    } rx_state_e;

    localparam logic [1:0] PAR_ODD   = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_SPACE = 2'b10;
    localparam logic [1:0] PAR_MARK  = 2'b11;

    localparam logic [1:0] BITS_5 = 2'b00;
    localparam logic [1:0] BITS_6 = 2'b01;
    localparam logic [1:0] BITS_7 = 2'b10;
    localparam logic [1:0] BITS_8 = 2'b11;

    // Bits enter at the MSB, so an N-bit word sits in the top N positions.
    function automatic logic [DATA_W-1:0] align_data(input logic [DATA_W-1:0] sr,
                                                     input logic [1:0]        bits);
        return sr >> (2'd3 - bits);
    endfunction

    function automatic logic exp_parity(input logic [DATA_W-1:0] data,
                                        input logic [1:0]        sel);
        logic p;
        case (sel)
            PAR_ODD:   p = ~^data;
            PAR_EVEN:  p = ^data;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b1;
        endcase
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_baud.sv
// ============================================================================
//  Module      : uart_rx_baud
//  Description : Baud counter for the UART receiver; flags half-period and
//                full-period (sample tick) points.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_baud
    import uart_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             half_o,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // If div shrinks below the count mid-frame, the natural 16-bit wrap
    // still brings the counter back to a match, so the FSM cannot stall.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear_i || (cnt_q == div_i)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_o = (cnt_q == (div_i >> 1));
    assign tick_o = (cnt_q == div_i);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver, 5..8 data bits, optional parity, one stop
//                bit, ready/valid byte output with error pulses.
//                Optional macro UART_RX_MAJORITY_EN: 3-sample majority vote.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic              cfg_en_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic              cfg_parity_en_i,
    input  logic [1:0]        cfg_parity_sel_i,
    input  logic [1:0]        cfg_bits_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              busy_o,
    output logic              err_parity_o,
    output logic              err_frame_o,
    output logic              err_overrun_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       line_w;
    logic       samp_w;

    always_comb begin
        sync_d = {sync_q[0], rx_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Line is delayed one cycle so the centre sample has a neighbour on each side.
    logic [1:0] dly_q;
    logic [1:0] dly_d;

    always_comb begin
        dly_d = {dly_q[0], sync_q[1]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dly_q <= 2'b11;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign line_w = dly_q[0];
    assign samp_w = (sync_q[1] & dly_q[0]) | (sync_q[1] & dly_q[1]) | (dly_q[0] & dly_q[1]);
`else
    assign line_w = sync_q[1];
    assign samp_w = sync_q[1];
`endif

    logic half_w;
    logic tick_w;
    logic baud_clear_w;

    uart_rx_baud u_baud (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (baud_clear_w),
        .div_i   (cfg_div_i),
        .half_o  (half_w),
        .tick_o  (tick_w)
    );

    rx_state_e state_q;
    rx_state_e state_d;

    logic [DATA_W-1:0] shift_q,    shift_d;
    logic [2:0]        bit_cnt_q,  bit_cnt_d;
    logic              par_err_q,  par_err_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              valid_q,    valid_d;
    logic              err_par_q,  err_par_d;
    logic              err_frm_q,  err_frm_d;
    logic              err_ovr_q,  err_ovr_d;

    logic              last_bit_w;
    logic [DATA_W-1:0] rx_byte_w;
    logic              busy_w;
    logic              shift_en_w;
    logic              par_chk_w;
    logic              frame_done_w;

    assign last_bit_w = (bit_cnt_q == ({1'b0, cfg_bits_i} + 3'd4));
    assign rx_byte_w  = align_data(shift_q, cfg_bits_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!cfg_en_i) begin
            state_d = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (!line_w) state_d = RX_START_BIT;
                end
                RX_START_BIT: begin
                    if (half_w) state_d = samp_w ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (tick_w && last_bit_w)
                        state_d = cfg_parity_en_i ? RX_PARITY : RX_STOP_BIT;
                end
                RX_PARITY: begin
                    if (tick_w) state_d = RX_STOP_BIT;
                end
                RX_STOP_BIT: begin
                    if (tick_w) state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // Restarting the counter at mid-start-bit puts every later tick at bit centre.
    always_comb begin
        busy_w       = (state_q != RX_IDLE);
        baud_clear_w = !cfg_en_i || (state_q == RX_IDLE)
                       || ((state_q == RX_START_BIT) && half_w);
        shift_en_w   = cfg_en_i && (state_q == RX_DATA) && tick_w;
        par_chk_w    = cfg_en_i && (state_q == RX_PARITY) && tick_w;
        frame_done_w = cfg_en_i && (state_q == RX_STOP_BIT) && tick_w;
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        valid_d   = valid_q;
        err_par_d = 1'b0;
        err_frm_d = 1'b0;
        err_ovr_d = 1'b0;

        if (!cfg_en_i || (state_q == RX_IDLE)) begin
            bit_cnt_d = '0;
            par_err_d = 1'b0;
        end
        if (shift_en_w) begin
            shift_d   = {samp_w, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (par_chk_w) begin
            par_err_d = (samp_w != exp_parity(rx_byte_w, cfg_parity_sel_i));
        end
        if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
        // A pending unread byte wins; the new one is dropped and flagged.
        if (frame_done_w) begin
            if (valid_q && !rx_ready_i) begin
                err_ovr_d = 1'b1;
            end else begin
                data_d    = rx_byte_w;
                valid_d   = 1'b1;
                err_par_d = par_err_q;
                err_frm_d = !samp_w;
            end
        end
        if (!cfg_en_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_par_q <= err_par_d;
            err_frm_q <= err_frm_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    assign busy_o        = busy_w;
    assign rx_data_o     = data_q;
    assign rx_valid_o    = valid_q;
    assign err_parity_o  = err_par_q;
    assign err_frame_o   = err_frm_q;
    assign err_overrun_o = err_ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed, table-driven bench for uart_rx at div=15.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int BIT = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_i = 1'b1;
    logic        cfg_en_i = 1'b1;
    logic [15:0] cfg_div_i = 16'd15;
    logic        cfg_parity_en_i = 1'b0;
    logic [1:0]  cfg_parity_sel_i = 2'b00;
    logic [1:0]  cfg_bits_i = 2'b11;
    logic        rx_ready_i = 1'b0;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        busy_o;
    logic        err_parity_o;
    logic        err_frame_o;
    logic        err_overrun_o;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .rx_i             (rx_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_div_i        (cfg_div_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_parity_sel_i (cfg_parity_sel_i),
        .cfg_bits_i       (cfg_bits_i),
        .rx_data_o        (rx_data_o),
        .rx_valid_o       (rx_valid_o),
        .rx_ready_i       (rx_ready_i),
        .busy_o           (busy_o),
        .err_parity_o     (err_parity_o),
        .err_frame_o      (err_frame_o),
        .err_overrun_o    (err_overrun_o)
    );

    int mon_perr = 0;
    int mon_ferr = 0;
    int mon_oerr = 0;
    int mon_vrise = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (err_parity_o)  mon_perr++;
        if (err_frame_o)   mon_ferr++;
        if (err_overrun_o) mon_oerr++;
        if (rx_valid_o && !prev_valid) mon_vrise++;
        prev_valid = rx_valid_o;
    end

    typedef struct {
        logic [7:0] data;
        logic [1:0] bits;
        logic       par_en;
        logic [1:0] par_sel;
        logic       par_bit;
        logic       stop_bit;
        logic [7:0] exp_data;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[9];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A low stop bit is held for most of the bit period, then the line idles.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] bits,
                              input logic pen, input logic pbit, input logic stop);
        rx_i = 1'b0;
        tick(BIT);
        for (int i = 0; i < int'(bits) + 5; i++) begin
            rx_i = d[i];
            tick(BIT);
        end
        if (pen) begin
            rx_i = pbit;
            tick(BIT);
        end
        if (stop) begin
            rx_i = 1'b1;
            tick(BIT);
        end else begin
            rx_i = 1'b0;
            tick(12);
            rx_i = 1'b1;
            tick(4);
        end
        tick(8);
    endtask

    task automatic handshake();
        rx_ready_i = 1'b1;
        tick(1);
        rx_ready_i = 1'b0;
    endtask

    int p0, f0, o0, v0;

    initial begin
        vecs[0] = '{8'hA5, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 8'hA5, 0, 0};
        vecs[1] = '{8'h35, 2'b10, 1'b1, 2'b01, 1'b1, 1'b1, 8'h35, 1, 0};
        vecs[2] = '{8'h35, 2'b10, 1'b1, 2'b01, 1'b0, 1'b1, 8'h35, 0, 0};
        vecs[3] = '{8'h3C, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 8'h3C, 0, 1};
        vecs[4] = '{8'h81, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 8'h81, 0, 0};
        vecs[5] = '{8'h13, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 8'h13, 0, 0};
        vecs[6] = '{8'h2A, 2'b01, 1'b1, 2'b11, 1'b1, 1'b1, 8'h2A, 0, 0};
        vecs[7] = '{8'h2A, 2'b01, 1'b1, 2'b10, 1'b1, 1'b1, 8'h2A, 1, 0};
        vecs[8] = '{8'hFF, 2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 8'hFF, 0, 0};

        @(posedge clk);
        #1;
        tick(3);
        check("reset_data",  32'(rx_data_o),  32'h00);
        check("reset_valid", 32'(rx_valid_o), 32'h0);
        check("reset_busy",  32'(busy_o),     32'h0);
        check("reset_errs",  32'({err_parity_o, err_frame_o, err_overrun_o}), 32'h0);
        rst_i = 1'b0;
        tick(4);

        for (int k = 0; k < 9; k++) begin
            cfg_bits_i       = vecs[k].bits;
            cfg_parity_en_i  = vecs[k].par_en;
            cfg_parity_sel_i = vecs[k].par_sel;
            p0 = mon_perr; f0 = mon_ferr; o0 = mon_oerr; v0 = mon_vrise;
            send_frame(vecs[k].data, vecs[k].bits, vecs[k].par_en,
                       vecs[k].par_bit, vecs[k].stop_bit);
            check($sformatf("v%0d_data", k),    32'(rx_data_o),       32'(vecs[k].exp_data));
            check($sformatf("v%0d_valid", k),   32'(rx_valid_o),      32'h1);
            check($sformatf("v%0d_vrise", k),   32'(mon_vrise - v0),  32'h1);
            check($sformatf("v%0d_perr", k),    32'(mon_perr - p0),   32'(vecs[k].exp_perr));
            check($sformatf("v%0d_ferr", k),    32'(mon_ferr - f0),   32'(vecs[k].exp_ferr));
            check($sformatf("v%0d_oerr", k),    32'(mon_oerr - o0),   32'h0);
            handshake();
            check($sformatf("v%0d_valid_clr", k), 32'(rx_valid_o),    32'h0);
        end

        // Overrun: second byte dropped while the first is unread.
        cfg_bits_i = 2'b11; cfg_parity_en_i = 1'b0;
        o0 = mon_oerr; v0 = mon_vrise; f0 = mon_ferr;
        send_frame(8'h11, 2'b11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 2'b11, 1'b0, 1'b0, 1'b1);
        check("ovr_data",  32'(rx_data_o),      32'h11);
        check("ovr_valid", 32'(rx_valid_o),     32'h1);
        check("ovr_pulse", 32'(mon_oerr - o0),  32'h1);
        check("ovr_vrise", 32'(mon_vrise - v0), 32'h1);
        check("ovr_ferr",  32'(mon_ferr - f0),  32'h0);

        // Short start glitch.
        p0 = mon_perr; f0 = mon_ferr; o0 = mon_oerr; v0 = mon_vrise;
        handshake();
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(40);
        check("glitch_busy",  32'(busy_o),          32'h0);
        check("glitch_valid", 32'(rx_valid_o),      32'h0);
        check("glitch_vrise", 32'(mon_vrise - v0),  32'h0);
        check("glitch_errs",  32'((mon_perr - p0) + (mon_ferr - f0) + (mon_oerr - o0)), 32'h0);

        // Reset mid-frame with a byte pending.
        send_frame(8'h77, 2'b11, 1'b0, 1'b0, 1'b1);
        rx_i = 1'b0; tick(BIT);
        rx_i = 1'b0; tick(BIT);
        rx_i = 1'b1; tick(BIT);
        rx_i = 1'b0; tick(BIT / 2);
        check("pre_rst_busy", 32'(busy_o), 32'h1);
        rst_i = 1'b1;
        tick(1);
        check("rst_busy",  32'(busy_o),     32'h0);
        check("rst_valid", 32'(rx_valid_o), 32'h0);
        check("rst_data",  32'(rx_data_o),  32'h00);
        rx_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        tick(4);
        check("post_rst_busy", 32'(busy_o), 32'h0);
        p0 = mon_perr; f0 = mon_ferr;
        send_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b1);
        check("c3_data",  32'(rx_data_o),  32'hC3);
        check("c3_valid", 32'(rx_valid_o), 32'h1);
        check("c3_errs",  32'((mon_perr - p0) + (mon_ferr - f0)), 32'h0);

        // Disabling the receiver drops the pending byte silently.
        p0 = mon_perr; f0 = mon_ferr; o0 = mon_oerr;
        cfg_en_i = 1'b0;
        tick(1);
        check("dis_valid", 32'(rx_valid_o), 32'h0);
        rx_i = 1'b0;
        tick(BIT * 2);
        check("dis_busy",  32'(busy_o), 32'h0);
        rx_i = 1'b1;
        tick(4);
        check("dis_errs",  32'((mon_perr - p0) + (mon_ferr - f0) + (mon_oerr - o0)), 32'h0);
        cfg_en_i = 1'b1;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
